// File: rtl/rv_pkg.sv
// Shared core definitions: architectural defaults and constants used by fetch and decode.
package rv_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP              = 32'h0000_0013;  // addi x0, x0, 0

  // Instruction word width is fixed by the ISA regardless of XLEN.
  localparam int          ILEN             = 32;

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO holding fetched (instr, pc) pairs; synchronous flush, caller guarantees
// no push when full and no pop when empty.
module fetch_queue
  import rv_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int QDEPTH = 4,
  localparam int AW    = $clog2(QDEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head,
  output logic             empty
);

  logic [WIDTH-1:0] mem [QDEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;

  // Pointers wrap naturally because QDEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr_reg] <= push_data;
  end

  // Head is read combinationally so decode sees it in the same cycle it becomes valid.
  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;
  assign empty = (count_reg == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues pipelined requests to a one-cycle
// instruction memory, buffers responses and hands them to decode via valid/ready.
module fetch_unit
  import rv_pkg::*;
#(
  parameter int               XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEFAULT),
  parameter int               QDEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic [ILEN-1:0]  imem_rdata,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ILEN-1:0]  out_instr,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_pc_plus4
);

  localparam int              CW         = $clog2(QDEPTH) + 1;
  localparam int              EW         = ILEN + XLEN;
  localparam logic [XLEN-1:0] WORD_MASK  = ~XLEN'(3);
  localparam logic [XLEN-1:0] RESET_ADDR = RESET_PC & WORD_MASK;

  logic [XLEN-1:0] fetch_pc_reg;
  logic [XLEN-1:0] fetch_pc_next;
  logic            inflight_reg;
  logic [XLEN-1:0] inflight_pc_reg;

  logic [CW-1:0]   q_count;
  logic [EW-1:0]   q_head;
  logic            q_empty;
  logic            q_push;
  logic            q_pop;
  logic            room;
  logic [XLEN-1:0] redirect_target;
  logic [XLEN-1:0] head_pc;
  logic [ILEN-1:0] head_instr;

  assign redirect_target = redirect_pc & WORD_MASK;

  // Room uses the registered count plus the response still owed by memory, so a
  // same-cycle dequeue never creates extra space.
  assign room     = (q_count + CW'(inflight_reg)) < CW'(QDEPTH);
  assign imem_req = rst & ~redirect_valid & room;
  assign imem_addr = fetch_pc_reg;

  assign q_push = inflight_reg & ~redirect_valid;
  assign q_pop  = out_valid & out_ready & ~redirect_valid;

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    if (redirect_valid)
      fetch_pc_next = redirect_target;
    else if (imem_req)
      fetch_pc_next = fetch_pc_reg + XLEN'(4);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_reg    <= RESET_ADDR;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= RESET_ADDR;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      inflight_reg <= imem_req;
      if (imem_req) inflight_pc_reg <= fetch_pc_reg;
    end
  end

  fetch_queue #(
    .WIDTH  (EW),
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (q_push),
    .push_data ({imem_rdata, inflight_pc_reg}),
    .pop       (q_pop),
    .count     (q_count),
    .head      (q_head),
    .empty     (q_empty)
  );

  assign head_instr = q_head[EW-1:XLEN];
  assign head_pc    = q_head[XLEN-1:0];

  // Outputs are forced to zero while the queue is empty so stale RAM contents never leak.
  assign out_valid    = ~q_empty;
  assign out_instr    = out_valid ? head_instr : '0;
  assign out_pc       = out_valid ? head_pc : '0;
  assign out_pc_plus4 = out_valid ? (head_pc + XLEN'(4)) : '0;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch front end that supersedes the bare PC register of the single-cycle core. It owns the program counter, issues pipelined requests to a one-cycle-latency instruction memory, buffers returned instructions in a small queue and hands them to decode over a valid/ready handshake. A redirect from execute (branch/jump) flushes all buffered and in-flight fetches and restarts fetch at the target.

## Interface
- XLEN, 32, address/PC width
- RESET_PC, 0, PC value loaded on reset
- QDEPTH, 4, instruction queue entries; power of two, ≥ 2

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- imem_req  out  1  fetch request this cycle
- imem_addr  out  XLEN  request address, bits [1:0] always 0
- imem_rdata  in  32  instruction; valid exactly one cycle after its request
- redirect_valid  in  1  redirect fetch this cycle
- redirect_pc  in  XLEN  redirect target; bits [1:0] ignored (forced 0)
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head
- out_instr  out  32  head instruction; 0 when out_valid=0
- out_pc  out  XLEN  head PC; 0 when out_valid=0
- out_pc_plus4  out  XLEN  out_pc + 4 mod 2^XLEN; 0 when out_valid=0

## Operation
- State: fetch_pc, inflight flag + inflight_pc, queue (instr, pc) with count 0..QDEPTH.
- Reset (rst=0): fetch_pc=RESET_PC, inflight=0, queue empty; outputs imem_req=0, imem_addr=RESET_PC, out_valid=0, out_instr/out_pc/out_pc_plus4=0.
- Request: imem_req = rst & !redirect_valid & (count + inflight < QDEPTH), using registered count (dequeue in same cycle gives no extra room). imem_addr = fetch_pc. On request: fetch_pc += 4 (wraps mod 2^XLEN), inflight<=1, inflight_pc<=fetch_pc; otherwise inflight<=0.
- Response: if inflight=1 in a cycle, imem_rdata and inflight_pc are written to the queue tail at that cycle's end.
- Dequeue: out_valid & out_ready pops head. Simultaneous push and pop: count unchanged.
- Redirect (redirect_valid=1): queue cleared, inflight cleared (pending response discarded), fetch_pc <= {redirect_pc[XLEN-1:2],2'b00}, no request issued that cycle. Redirect overrides any concurrent push/pop; a handshake completing in the redirect cycle counts as accepted by decode.
- Queue never overflows: room check includes in-flight response. Popping an empty queue is impossible (out_valid=0).

## Timing
- Cycle 0 = first cycle with rst=1: imem_req=1 at RESET_PC; rdata captured end of cycle 1; out_valid=1 in cycle 2.
- Redirect in cycle T: request at target in T+1, rdata T+2, out_valid at target in T+3.
- Steady state with out_ready=1: one instruction per cycle, consecutive PCs.
- out_ready=0: queue fills to QDEPTH, imem_req drops; with count=QDEPTH-1 and inflight=1 no new request. Resumes the cycle after a pop lowers count+inflight below QDEPTH.
- rst asserted mid-operation: immediate return to reset values, in-flight response ignored.

## Structure
- Shared package rv_pkg: XLEN default, RESET_PC default, NOP constant 32'h0000_0013 (for decode use).
- Sub-module fetch_queue: parametrised FIFO (width, QDEPTH) with synchronous flush, push, pop, count, head outputs; fetch_unit holds PC and request logic.

## Test plan
- Reset release, out_ready=1, imem returns addr-derived word: out_pc 0,4,8,12 on consecutive cycles from cycle 2, out_pc_plus4 = out_pc+4.
- out_ready=0 for 10 cycles after reset: exactly QDEPTH=4 requests (addrs 0..12), out_valid held, head pc 0; release out_ready → pcs 0..12 then 16 without gap or duplicate.
- redirect_valid with redirect_pc=0x103 at cycle 5: imem_req=0 in cycle 5, addr 0x100 in cycle 6, next out_pc=0x100 in cycle 8, no stale pcs emitted.
- Redirect coinciding with a push and a pop: queue empty next cycle, inflight response dropped, popped entry not re-emitted.
- RESET_PC=XLEN'hFFFF_FFF8: out_pc FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap).
- rst pulsed low mid-stream with queue half full: outputs return to reset values within the cycle; fetch restarts at RESET_PC.
